instrument_seq: RTL
===================

INSTRUMENT_SEQ -- requirements
Module: instrument_seq

Interface
REQ-001 Parameter NUM_NOTES, default 7, SHALL set the number of note channels (index 0..6 = C,D,E,F,G,A,B); legal range 1..16.
REQ-002 Parameter DEPTH, default 16, SHALL set the record buffer size in steps; power of two, 2..256.
REQ-003 Parameter TEMPO_DIV, default 25000000, SHALL set the clock cycles per auto-playback step; minimum 2.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 note_in  in  NUM_NOTES  note buttons, active-high, synchronous to clk.
REQ-007 mode  in  2  00 LIVE, 01 RECORD, 10 PLAY_AUTO, 11 PLAY_MANUAL.
REQ-008 step  in  1  manual advance button; its rising edge is the event.
REQ-009 note_out  out  NUM_NOTES  registered note drive to the tone stage.
REQ-010 seg_note  out  7  active-low seven-segment letter of the lowest-index active note_out bit, bit order {g,f,e,d,c,b,a}.
REQ-011 seg_step  out  7  active-low seven-segment hex digit of step_idx[3:0], same bit order.
REQ-012 step_idx  out  clog2(DEPTH)  current playback index, or write pointer in RECORD.
REQ-013 rec_count  out  clog2(DEPTH)+1  number of stored steps.
REQ-014 full  out  1  high when rec_count == DEPTH.

Function
REQ-015 The state machine SHALL have states LIVE, RECORD and PLAY, with the next state decoded from mode each cycle (01 gives RECORD, 1x gives PLAY, 00 gives LIVE).
REQ-016 In LIVE, note_out SHALL equal note_in from the previous cycle (1-cycle latency), with multiple simultaneous notes passed through unchanged.
REQ-017 Entering RECORD from any other state SHALL clear rec_count and the write pointer in that same cycle; the buffer contents need not be cleared.
REQ-018 In RECORD, note_out SHALL follow the LIVE rule, and each cycle with new_press = note_in & ~note_in_q nonzero SHALL write new_press to buffer[wr_ptr] and increment wr_ptr and rec_count.
REQ-019 In RECORD, presses SHALL be ignored while full = 1; no pointer wrap and no overwrite.
REQ-020 Entering PLAY SHALL set step_idx to 0 and clear the tempo counter.
REQ-021 In PLAY, note_out SHALL equal buffer[step_idx], registered, 1 cycle after step_idx changes.
REQ-022 In PLAY_AUTO, step_idx SHALL advance once every TEMPO_DIV cycles; in PLAY_MANUAL, it SHALL advance 1 cycle after each step rising edge, and a step edge while in PLAY_AUTO SHALL be ignored.
REQ-023 Advancing from step_idx == rec_count-1 SHALL wrap to 0.
REQ-024 In PLAY with rec_count == 0, note_out SHALL be all zero and step_idx SHALL hold at 0.
REQ-025 A switch between PLAY_AUTO and PLAY_MANUAL SHALL keep step_idx and clear the tempo counter.
REQ-026 The step edge detector SHALL use one registered copy of step; a held step SHALL produce exactly one advance.
REQ-027 seg_note SHALL encode C,d,E,F,g,A,b for indices 0..6 and SHALL be blank (7'h7F) when note_out is zero or the lowest active index is >= 7.
REQ-028 seg_step SHALL encode hex 0..F.
REQ-029 seg_note and seg_step SHALL be combinational from the registered state.
REQ-030 The buffer SHALL be DEPTH x NUM_NOTES registers or inferred RAM with a 1-cycle read.

Reset
REQ-031 While reset = 1 at a clk edge, the state SHALL be LIVE and note_out, step_idx, rec_count, wr_ptr, the tempo counter, note_in_q and step_q SHALL be 0.
REQ-032 While reset = 1 at a clk edge, full SHALL be 0, seg_note SHALL be 7'h7F, and seg_step SHALL show 0 (7'h40).
REQ-033 A reset asserted mid-RECORD or mid-PLAY SHALL discard the recording (rec_count = 0) and take effect on the same edge.
REQ-034 After reset deasserts, the block SHALL follow mode from the next edge.

Verification
REQ-035 LIVE: note_in = 7'b0000001 -> next cycle note_out = 7'b0000001, seg_note = C (7'h46); note_in = 7'b1000001 -> note_out = 7'b1000001, seg_note still C.
REQ-036 RECORD: press C, E, G as separate 1-cycle pulses, with one held 5 cycles -> rec_count = 3, buffer = {001, 004, 010 hex}, and the held press is recorded once.
REQ-037 Full: DEPTH = 4, 6 distinct presses -> rec_count = 4, full = 1, presses 5 and 6 not stored, wr_ptr = 3.
REQ-038 PLAY_MANUAL with 3 steps: 4 step pulses -> step_idx sequence 0,1,2,0,1 and note_out matches the buffer each step; step held high for 10 cycles -> exactly 1 advance.
REQ-039 PLAY_AUTO with TEMPO_DIV = 4 and 3 steps -> step_idx advances at cycles 4, 8, 12 after entry and wraps to 0; rec_count = 0 -> note_out = 0 and seg_note blank.
REQ-040 Reset asserted mid-PLAY -> next edge: state LIVE, note_out = 0, rec_count = 0, seg_step = 7'h40.

Source files
------------

// File: rtl/instrument_seq.sv
`default_nettype none
// ============================================================================
// Module   : instrument_seq
// Purpose  : Note sequencer for a simple keyboard instrument. It has three
//            uses: live pass-through, recording of note presses into a small
//            step buffer, and playback of that buffer. Playback advances
//            either on a tempo timer or on a manual step button.
// Ports    : clk        - sole clock, rising edge
//            reset      - synchronous, active-high reset
//            note_in    - note buttons, one bit per note (0..6 = C..B)
//            mode       - 00 LIVE, 01 RECORD, 10 PLAY_AUTO, 11 PLAY_MANUAL
//            step       - manual advance button (rising edge is the event)
//            note_out   - registered note drive to the tone stage
//            seg_note   - active-low 7-seg letter of lowest active note_out bit
//            seg_step   - active-low 7-seg hex digit of step_idx[3:0]
//            step_idx   - playback index, or write pointer while recording
//            rec_count  - number of stored steps
//            full       - rec_count == DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module instrument_seq #(
  parameter int NUM_NOTES = 7,
  parameter int DEPTH     = 16,
  parameter int TEMPO_DIV = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_NOTES-1:0]       note_in,
  input  logic [1:0]                 mode,
  input  logic                       step,
  output logic [NUM_NOTES-1:0]       note_out,
  output logic [6:0]                 seg_note,
  output logic [6:0]                 seg_step,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [$clog2(DEPTH):0]     rec_count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TEMPO_DIV);

  typedef enum logic [1:0] {
    ST_LIVE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [NUM_NOTES-1:0]  note_in_q;
  logic [NUM_NOTES-1:0]  new_press;
  logic                  step_q;
  logic                  step_rise;
  logic                  manual_q;   // mode[0] of the previous cycle
  logic [AW-1:0]         play_idx;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         play_idx_adv;
  logic [TW-1:0]         tempo_cnt;
  logic                  tempo_hit;
  logic                  rec_we;
  logic [NUM_NOTES-1:0]  buffer [DEPTH];

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= ST_LIVE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = ST_LIVE;
    if (mode[1])      state_nx = ST_PLAY;
    else if (mode[0]) state_nx = ST_RECORD;
  end

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  assign new_press = note_in & ~note_in_q;
  assign step_rise = step & ~step_q;
  assign full      = (rec_count == (AW+1)'(DEPTH));
  assign tempo_hit = (tempo_cnt == TW'(TEMPO_DIV - 1));

  // A write only happens once RECORD is already established; the entry edge
  // is spent clearing the count and pointer.
  assign rec_we = !reset && (state == ST_RECORD) && (state_nx == ST_RECORD) &&
                  (|new_press) && !full;

  // Wrap after the last stored step; an empty recording pins the index at 0.
  always_comb begin
    play_idx_adv = play_idx + AW'(1);
    if ((rec_count == '0) || (({1'b0, play_idx} + (AW+1)'(1)) == rec_count))
      play_idx_adv = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_in_q <= '0;
      step_q    <= 1'b0;
      manual_q  <= 1'b0;
      note_out  <= '0;
      play_idx  <= '0;
      wr_ptr    <= '0;
      rec_count <= '0;
      tempo_cnt <= '0;
    end else begin
      note_in_q <= note_in;
      step_q    <= step;
      manual_q  <= mode[0];
      case (state_nx)
        ST_RECORD: begin
          note_out <= note_in;
          if (state != ST_RECORD) begin
            rec_count <= '0;
            wr_ptr    <= '0;
          end else if (rec_we) begin
            rec_count <= rec_count + (AW+1)'(1);
            // The pointer parks on the last slot rather than wrapping.
            if (wr_ptr != AW'(DEPTH - 1)) wr_ptr <= wr_ptr + AW'(1);
          end
        end
        ST_PLAY: begin
          if (state != ST_PLAY) begin
            play_idx  <= '0;
            tempo_cnt <= '0;
            note_out  <= '0;
          end else begin
            note_out <= (rec_count == '0) ? '0 : buffer[play_idx];
            if (manual_q != mode[0]) begin
              // Auto/manual switch: keep the position, restart the tempo.
              tempo_cnt <= '0;
            end else if (mode[0]) begin
              tempo_cnt <= '0;
              if (step_rise) play_idx <= play_idx_adv;
            end else if (tempo_hit) begin
              tempo_cnt <= '0;
              play_idx  <= play_idx_adv;
            end else begin
              tempo_cnt <= tempo_cnt + TW'(1);
            end
          end
        end
        default: note_out <= note_in;
      endcase
    end
  end

  // Step buffer: no reset, contents are qualified by rec_count.
  always_ff @(posedge clk) begin
    if (rec_we) buffer[wr_ptr] <= new_press;
  end

  // --------------------------------------------------------------------------
  // Display outputs
  // --------------------------------------------------------------------------
  assign step_idx = (state == ST_RECORD) ? wr_ptr : play_idx;

  logic [4:0] low_idx;
  logic       low_found;

  always_comb begin
    low_idx   = 5'd0;
    low_found = 1'b0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (note_out[i]) begin
        low_idx   = 5'(i);
        low_found = 1'b1;
      end
    end
    seg_note = 7'h7F;
    if (low_found) begin
      case (low_idx)
        5'd0:    seg_note = 7'h46;  // C
        5'd1:    seg_note = 7'h21;  // d
        5'd2:    seg_note = 7'h06;  // E
        5'd3:    seg_note = 7'h0E;  // F
        5'd4:    seg_note = 7'h10;  // g
        5'd5:    seg_note = 7'h08;  // A
        5'd6:    seg_note = 7'h03;  // b
        default: seg_note = 7'h7F;
      endcase
    end
  end

  logic [3:0] hex_digit;
  assign hex_digit = 4'(step_idx);

  always_comb begin
    seg_step = 7'h7F;
    case (hex_digit)
      4'h0: seg_step = 7'h40;
      4'h1: seg_step = 7'h79;
      4'h2: seg_step = 7'h24;
      4'h3: seg_step = 7'h30;
      4'h4: seg_step = 7'h19;
      4'h5: seg_step = 7'h12;
      4'h6: seg_step = 7'h02;
      4'h7: seg_step = 7'h78;
      4'h8: seg_step = 7'h00;
      4'h9: seg_step = 7'h10;
      4'hA: seg_step = 7'h08;
      4'hB: seg_step = 7'h03;
      4'hC: seg_step = 7'h46;
      4'hD: seg_step = 7'h21;
      4'hE: seg_step = 7'h06;
      4'hF: seg_step = 7'h0E;
      default: seg_step = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire
